// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM stream reader: FSM state encoding and the
// buffered read entry. Entry widths follow the 1024x32 RAM IP.
package ram_rd_pkg;

  localparam int PKG_ADDR_W = 10;
  localparam int PKG_DATA_W = 32;
  localparam int ERR_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic [PKG_ADDR_W-1:0] addr;
    logic                  last;
  } rd_entry_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Synchronous FIFO of read entries (data, address tag, last flag) that
// decouples RAM read returns from the output stream.
module ram_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  rd_entry_t                    wdata,
  input  logic                         pop,
  output rd_entry_t                    rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rd_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments (<=) so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential read master for one RAM port: issues credit-limited reads,
// buffers returns, streams them out with a last marker and optional data==address check.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W     = PKG_ADDR_W,
  parameter int DATA_W     = PKG_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              chk_en,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remain;
  logic              chk_q;

  logic [RD_LAT-1:0] vld_sr;
  logic [ADDR_W-1:0] addr_sr [RD_LAT];
  logic              last_sr [RD_LAT];

  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  rd_entry_t         push_entry;
  rd_entry_t         head;

  logic              credit;
  logic              start_cmd;
  logic              issue;
  logic              issue_last;
  logic              pop;
  logic              cmd_end;

  // NOTE: every always_comb output gets a default before any conditional
  // logic so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_sr[i]);
  end

  // Every in-flight read already owns a FIFO slot, so returns never overflow.
  assign credit     = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  // The first read goes out in the start cycle itself to reach RD_LAT+1 latency.
  assign start_cmd  = (state == ST_IDLE) && start && (len != '0);
  assign issue      = start_cmd || ((state == ST_ISSUE) && credit);
  assign issue_last = start_cmd ? (len == (ADDR_W + 1)'(1)) : (remain == (ADDR_W + 1)'(1));

  assign ram_en   = issue;
  assign ram_we   = 1'b0;
  assign ram_addr = start_cmd ? base_addr : cur_addr;

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : head.data;
  assign m_last  = !fifo_empty && head.last;
  assign pop     = m_valid && m_ready;
  assign cmd_end = pop && head.last && (inflight == '0);

  always_comb begin
    push_entry      = '0;
    push_entry.data = ram_dout;
    push_entry.addr = addr_sr[RD_LAT-1];
    push_entry.last = last_sr[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_sr[i] <= vld_sr[i-1];
      vld_sr[0] <= issue;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      addr_sr[i] <= addr_sr[i-1];
      last_sr[i] <= last_sr[i-1];
    end
    addr_sr[0] <= ram_addr;
    last_sr[0] <= issue_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      chk_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (pop && chk_q && (m_data != DATA_W'(head.addr)) && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            err_cnt <= '0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              chk_q    <= chk_en;
              busy     <= 1'b1;
              cur_addr <= base_addr + ADDR_W'(1);
              remain   <= len - (ADDR_W + 1)'(1);
              state    <= (len == (ADDR_W + 1)'(1)) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            remain   <= remain - (ADDR_W + 1)'(1);
            if (remain == (ADDR_W + 1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cmd_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ram_rd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_sr[RD_LAT-1]),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: two instances (RD_LAT 1 and 2) share stimulus and
// are checked every cycle against a queue-based model of the expected stream.
module tb_ram_stream_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] len = '0;
  logic        chk_en = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;

    logic        ram_en, ram_we, m_valid, m_last, busy, done;
    logic [9:0]  ram_addr;
    logic [31:0] ram_dout, m_data, s1, s2;
    logic [15:0] err_cnt;

    ram_stream_reader #(
      .ADDR_W (10), .DATA_W (32), .RD_LAT (LAT), .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr),
      .len (len), .chk_en (chk_en), .ram_en (ram_en), .ram_we (ram_we),
      .ram_addr (ram_addr), .ram_dout (ram_dout), .m_valid (m_valid),
      .m_ready (m_ready), .m_data (m_data), .m_last (m_last), .busy (busy),
      .done (done), .err_cnt (err_cnt)
    );

    // RAM port model: data appears LAT cycles after the enabled request.
    always @(posedge clk) begin
      s1 <= ram_en ? mem[ram_addr] : 32'hxxxx_xxxx;
      s2 <= s1;
    end
    assign ram_dout = (LAT == 1) ? s1 : s2;

    logic [32:0] exp_q [$];
    logic [9:0]  exp_addr_q [$];
    logic [31:0] got [$];
    bit          mbusy = 1'b0;
    bit          done_due = 1'b0;
    bit          seen_first = 1'b0;
    int          exp_err = 0;
    int          start_cyc = 0;
    int          outstanding = 0;
    int          valid_cycles = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_addr_q.delete();
        mbusy = 1'b0;
        done_due = 1'b0;
        outstanding = 0;
      end else begin
        if (done_due) mbusy = 1'b0;
        check($sformatf("L%0d busy", g), 32'(busy), 32'(mbusy));
        check($sformatf("L%0d done", g), 32'(done), 32'(done_due));
        if (done) done_cnt++;
        if (done_due) check($sformatf("L%0d err_cnt at done", g), 32'(err_cnt), 32'(exp_err));
        done_due = 1'b0;

        if (start && !mbusy) begin
          got.delete();
          valid_cycles = 0;
          seen_first = 1'b0;
          start_cyc = cyc;
          exp_err = 0;
          if (len == '0) begin
            done_due = 1'b1;
            check($sformatf("L%0d no access on len0", g), 32'(ram_en), 32'd0);
          end else begin
            mbusy = 1'b1;
            for (int i = 0; i < int'(len); i++) begin
              int a;
              a = (int'(base_addr) + i) % 1024;
              exp_addr_q.push_back(10'(a));
              exp_q.push_back({(i == int'(len) - 1), mem[a]});
              if (chk_en && mem[a] != 32'(a) && exp_err < 65535) exp_err++;
            end
          end
        end

        if (ram_en) begin
          check($sformatf("L%0d ram_we", g), 32'(ram_we), 32'd0);
          if (exp_addr_q.size() == 0) begin
            check($sformatf("L%0d spurious ram_en", g), 32'(ram_en), 32'd0);
          end else begin
            check($sformatf("L%0d ram_addr", g), 32'(ram_addr), 32'(exp_addr_q.pop_front()));
            outstanding++;
            check($sformatf("L%0d credit bound", g), 32'(outstanding <= DEPTH), 32'd1);
          end
        end

        if (m_valid) begin
          valid_cycles++;
          if (!seen_first) begin
            check($sformatf("L%0d first latency", g), 32'(cyc - start_cyc), 32'(LAT + 1));
            seen_first = 1'b1;
          end
          if (exp_q.size() == 0) begin
            check($sformatf("L%0d unexpected m_valid", g), 32'(m_valid), 32'd0);
          end else begin
            check($sformatf("L%0d m_data", g), m_data, exp_q[0][31:0]);
            check($sformatf("L%0d m_last", g), 32'(m_last), 32'(exp_q[0][32]));
            if (m_ready) begin
              got.push_back(m_data);
              outstanding--;
              if (exp_q[0][32]) done_due = 1'b1;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic set_ready(input int mode);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input int d0, input int d1, input int mode);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (lane[0].done_cnt != d0 && lane[1].done_cnt != d1) begin
        ok = 1'b1;
        break;
      end
      set_ready(mode);
      @(posedge clk);
      #1;
    end
    check("command completes in budget", 32'(ok), 32'd1);
    m_ready = 1'b1;
  endtask

  task automatic run_cmd(input logic [9:0] b, input logic [10:0] l, input bit c, input int mode);
    int d0, d1;
    d0 = lane[0].done_cnt;
    d1 = lane[1].done_cnt;
    base_addr = b;
    len = l;
    chk_en = c;
    start = 1'b1;
    set_ready(mode);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, d1, mode);
  endtask

  initial begin
    bit ok;
    int d0, d1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check("L0 reset ctl", {lane[0].ram_en, lane[0].ram_addr, lane[0].m_valid, lane[0].m_last,
                           lane[0].busy, lane[0].done, lane[0].err_cnt}, 32'd0);
    check("L0 reset data", lane[0].m_data, 32'd0);
    check("L1 reset ctl", {lane[1].ram_en, lane[1].ram_addr, lane[1].m_valid, lane[1].m_last,
                           lane[1].busy, lane[1].done, lane[1].err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic sweep from 0 at full rate.
    run_cmd(10'd0, 11'd8, 1'b1, 0);
    check("t1 word count", 32'(lane[0].got.size()), 32'd8);
    check("t1 word0", lane[0].got[0], 32'd0);
    check("t1 word7", lane[0].got[7], 32'd7);
    check("t1 L0 no bubbles", 32'(lane[0].valid_cycles), 32'd8);
    check("t1 L1 no bubbles", 32'(lane[1].valid_cycles), 32'd8);
    check("t1 err", 32'(lane[0].err_cnt), 32'd0);

    // Address wrap at the top of the RAM.
    run_cmd(10'd1020, 11'd8, 1'b1, 0);
    check("t2 word0", lane[0].got[0], 32'd1020);
    check("t2 word3", lane[1].got[3], 32'd1023);
    check("t2 word4", lane[0].got[4], 32'd0);
    check("t2 word7", lane[1].got[7], 32'd3);

    // Alternating backpressure.
    m_ready = 1'b0;
    run_cmd(10'd100, 11'd16, 1'b1, 1);
    check("t3 L1 word count", 32'(lane[1].got.size()), 32'd16);
    check("t3 L1 word15", lane[1].got[15], 32'd115);

    // Pattern check against a corrupted word.
    mem[5] = 32'hDEAD_BEEF;
    run_cmd(10'd0, 11'd10, 1'b0, 0);
    check("t4 err chk off", 32'(lane[0].err_cnt), 32'd0);
    run_cmd(10'd0, 11'd10, 1'b1, 0);
    check("t4 L0 err chk on", 32'(lane[0].err_cnt), 32'd1);
    check("t4 L1 err chk on", 32'(lane[1].err_cnt), 32'd1);
    mem[5] = 32'd5;

    // Zero-length command clears err_cnt and only pulses done.
    run_cmd(10'd7, 11'd0, 1'b1, 0);
    check("t5 err cleared", 32'(lane[0].err_cnt), 32'd0);

    // Second start during an active command is ignored.
    d0 = lane[0].done_cnt;
    d1 = lane[1].done_cnt;
    base_addr = 10'd200; len = 11'd4; chk_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 base_addr = 10'd500; len = 11'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, d1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t6 L0 words", 32'(lane[0].got.size()), 32'd4);
    check("t6 L1 words", 32'(lane[1].got.size()), 32'd4);
    check("t6 last word", lane[0].got[3], 32'd203);

    // Reset in the middle of a command.
    mem[1] = 32'h1234;
    base_addr = 10'd0; len = 11'd8; chk_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (lane[0].got.size() >= 3) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("t7 three words before reset", 32'(ok), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7 L0 async reset ctl", {lane[0].ram_en, lane[0].ram_addr, lane[0].m_valid,
                                    lane[0].m_last, lane[0].busy, lane[0].done, lane[0].err_cnt}, 32'd0);
    check("t7 L0 async reset data", lane[0].m_data, 32'd0);
    check("t7 L1 async reset ctl", {lane[1].ram_en, lane[1].ram_addr, lane[1].m_valid,
                                    lane[1].m_last, lane[1].busy, lane[1].done, lane[1].err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem[1] = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    run_cmd(10'd0, 11'd2, 1'b1, 0);
    check("t7 restart word0", lane[0].got[0], 32'd0);
    check("t7 restart word1", lane[1].got[1], 32'd1);

    // Randomised commands with random backpressure and sparse corruption.
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'(i);
    for (int k = 0; k < 12; k++) begin
      logic [10:0] l;
      l = (k == 5) ? 11'd0 : 11'(1 + $urandom_range(0, 39));
      run_cmd(10'($urandom_range(0, 1023)), l, 1'($urandom_range(0, 1)), 2);
    end
    run_cmd(10'd3, 11'd1024, 1'b1, 2);
    check("full sweep words", 32'(lane[1].got.size()), 32'd1024);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
